// File: rtl/series_accum_pkg.sv
// series_accum_pkg
//   Shared types for the multi-channel series accumulator.
//   mode_e   : per-series reduction mode, latched on the first beat.
//   ch_bits(): channel tag width, never narrower than one bit.
package series_accum_pkg;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_MIN  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/series_accum_lane.sv
// series_accum_lane
//   One channel of the series accumulator: holds busy/mode/acc/cnt/ovf and
//   computes the next state for a beat steered to this channel.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   beat_i         accepted beat addressed to this channel (one-hot from top)
//   first_i/last_i series framing of the beat
//   mode_i         reduction mode (used only on first beats)
//   data_i         sample
//   busy_o         series open on this channel
//   res_vld_o      beat closes a series; res_* carry the final result
//   res_acc_o/res_cnt_o/res_ovf_o  updated state (result when res_vld_o)
//   err_o          beat is a protocol error on this channel
module series_accum_lane
  import series_accum_pkg::*;
#(
  parameter int NOF_BITS = 32,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                beat_i,
  input  logic                first_i,
  input  logic                last_i,
  input  mode_e               mode_i,
  input  logic [NOF_BITS-1:0] data_i,
  output logic                busy_o,
  output logic                res_vld_o,
  output logic [NOF_BITS:0]   res_acc_o,
  output logic [CNT_BITS-1:0] res_cnt_o,
  output logic                res_ovf_o,
  output logic                err_o
);

  typedef struct packed {
    logic                busy;
    mode_e               mode;
    logic [NOF_BITS:0]   acc;
    logic [CNT_BITS-1:0] cnt;
    logic                ovf;
  } ch_state_t;

  ch_state_t             st_q, st_d;
  logic [NOF_BITS:0]     data_x;
  logic [NOF_BITS+1:0]   sum;

  always_comb begin
    data_x    = {1'b0, data_i};
    // One extra bit above acc catches the carry out of bit NOF_BITS.
    sum       = {1'b0, st_q.acc} + {2'b00, data_i};
    st_d      = st_q;
    res_vld_o = 1'b0;
    err_o     = 1'b0;
    if (beat_i) begin
      if (first_i) begin
        // A first beat always (re)starts the series; an open one is dropped.
        st_d.busy = !last_i;
        st_d.mode = (mode_i == MODE_RSVD) ? MODE_SUM : mode_i;
        st_d.acc  = data_x;
        st_d.cnt  = CNT_BITS'(1);
        st_d.ovf  = 1'b0;
        res_vld_o = last_i;
        err_o     = st_q.busy || (mode_i == MODE_RSVD);
      end else if (st_q.busy) begin
        case (st_q.mode)
          MODE_MIN: if (data_x < st_q.acc) st_d.acc = data_x;
          MODE_MAX: if (data_x > st_q.acc) st_d.acc = data_x;
          default: begin
            if (sum[NOF_BITS+1]) begin
              st_d.acc = '1;
              st_d.ovf = 1'b1;
            end else begin
              st_d.acc = sum[NOF_BITS:0];
            end
          end
        endcase
        // Count saturates; a beat beyond all-ones flags overflow.
        if (&st_q.cnt) st_d.ovf = 1'b1;
        else           st_d.cnt = st_q.cnt + CNT_BITS'(1);
        st_d.busy = !last_i;
        res_vld_o = last_i;
      end else begin
        err_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  assign busy_o    = st_q.busy;
  assign res_acc_o = st_d.acc;
  assign res_cnt_o = st_d.cnt;
  assign res_ovf_o = st_d.ovf;

endmodule

// File: rtl/series_accum_mc.sv
// series_accum_mc
//   Multi-channel streaming series reducer (SUM/MIN/MAX) with a single
//   registered valid/ready result port.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid_i/in_ready_o        input beat handshake
//   in_ch_i                      channel tag
//   in_first_i/in_last_i         series framing
//   in_mode_i                    reduction mode (first beat only)
//   in_data_i                    sample
//   out_valid_o/out_ready_i      result handshake
//   out_ch_o/out_data_o/out_count_o/out_ovf_o  result fields
//   busy_o                       per-channel series-open flags
//   err_o                        one-cycle protocol error pulse
module series_accum_mc
  import series_accum_pkg::*;
#(
  parameter  int NOF_BITS = 32,
  parameter  int NOF_CH   = 4,
  parameter  int CNT_BITS = 8,
  localparam int CH_BITS  = ch_bits(NOF_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [CH_BITS-1:0]  in_ch_i,
  input  logic                in_first_i,
  input  logic                in_last_i,
  input  logic [1:0]          in_mode_i,
  input  logic [NOF_BITS-1:0] in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CH_BITS-1:0]  out_ch_o,
  output logic [NOF_BITS:0]   out_data_o,
  output logic [CNT_BITS-1:0] out_count_o,
  output logic                out_ovf_o,
  output logic [NOF_CH-1:0]   busy_o,
  output logic                err_o
);

  logic                              accept, ch_oob;
  logic [NOF_CH-1:0]                 beat_en, lane_vld, lane_err, lane_ovf;
  logic [NOF_CH-1:0][NOF_BITS:0]     lane_acc;
  logic [NOF_CH-1:0][CNT_BITS-1:0]   lane_cnt;

  logic                res_vld, res_ovf;
  logic [NOF_BITS:0]   res_acc;
  logic [CNT_BITS-1:0] res_cnt;

  logic                out_valid_q;
  logic [CH_BITS-1:0]  out_ch_q;
  logic [NOF_BITS:0]   out_data_q;
  logic [CNT_BITS-1:0] out_count_q;
  logic                out_ovf_q;
  logic                err_q, err_d;

  // Single output register: a new result may load in the same cycle the
  // old one is taken, so there is no bubble between results.
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign ch_oob     = (int'(in_ch_i) >= NOF_CH);

  always_comb begin
    beat_en = '0;
    if (accept && !ch_oob)
      for (int i = 0; i < NOF_CH; i++) beat_en[i] = (int'(in_ch_i) == i);
  end

  for (genvar g = 0; g < NOF_CH; g++) begin : g_lane
    series_accum_lane #(
      .NOF_BITS (NOF_BITS),
      .CNT_BITS (CNT_BITS)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .beat_i    (beat_en[g]),
      .first_i   (in_first_i),
      .last_i    (in_last_i),
      .mode_i    (mode_e'(in_mode_i)),
      .data_i    (in_data_i),
      .busy_o    (busy_o[g]),
      .res_vld_o (lane_vld[g]),
      .res_acc_o (lane_acc[g]),
      .res_cnt_o (lane_cnt[g]),
      .res_ovf_o (lane_ovf[g]),
      .err_o     (lane_err[g])
    );
  end

  // beat_en is one-hot or zero, so this priority mux is a plain select.
  always_comb begin
    res_vld = 1'b0;
    res_acc = '0;
    res_cnt = '0;
    res_ovf = 1'b0;
    for (int i = 0; i < NOF_CH; i++) begin
      if (beat_en[i]) begin
        res_vld = lane_vld[i];
        res_acc = lane_acc[i];
        res_cnt = lane_cnt[i];
        res_ovf = lane_ovf[i];
      end
    end
  end

  assign err_d = accept && (ch_oob || (|lane_err));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_d;
      if (res_vld) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= in_ch_i;
        out_data_q  <= res_acc;
        out_count_q <= res_cnt;
        out_ovf_q   <= res_ovf;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign out_data_o  = out_data_q;
  assign out_count_o = out_count_q;
  assign out_ovf_o   = out_ovf_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_series_accum_mc.sv
module tb_series_accum_mc;
  localparam int NB = 32, NC = 4, CB = 8, CHB = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [CHB-1:0] in_ch = '0;
  logic [1:0]     in_mode = '0;
  logic [NB-1:0]  in_data = '0;
  logic           in_ready, out_valid, out_ovf, err;
  logic [CHB-1:0] out_ch;
  logic [NB:0]    out_data;
  logic [CB-1:0]  out_count;
  logic [NC-1:0]  busy;

  always #5 clk = ~clk;

  series_accum_mc #(.NOF_BITS(NB), .NOF_CH(NC), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ch_i(in_ch),
    .in_first_i(in_first), .in_last_i(in_last), .in_mode_i(in_mode),
    .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch),
    .out_data_o(out_data), .out_count_o(out_count), .out_ovf_o(out_ovf),
    .busy_o(busy), .err_o(err)
  );

  typedef struct {
    logic [CHB-1:0] ch;
    logic [NB:0]    data;
    logic [CB-1:0]  cnt;
    logic           ovf;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [NB:0] d, input int cnt, input bit ovf);
    exp_t e;
    e.ch = CHB'(ch); e.data = d; e.cnt = CB'(cnt); e.ovf = ovf;
    sb.push_back(e);
  endtask

  // A handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      chk("result_expected", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("res_ch",    64'(out_ch),    64'(e.ch));
        chk("res_data",  64'(out_data),  64'(e.data));
        chk("res_count", 64'(out_count), 64'(e.cnt));
        chk("res_ovf",   64'(out_ovf),   64'(e.ovf));
      end
    end
  end

  // Drive one beat and hold it until accepted; returns 1 ns after the
  // accepting edge, where err reflects that beat.
  task automatic beat(input int ch, input bit f, input bit l, input int m,
                      input logic [NB-1:0] d);
    int n = 0;
    in_valid = 1'b1; in_ch = CHB'(ch); in_first = f; in_last = l;
    in_mode = 2'(m); in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) chk("beat_accept_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ch",    64'(out_ch),    64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    chk("rst_out_ovf",   64'(out_ovf),   64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_err",       64'(err),       64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);

    // Ch0 SUM 10,20,30
    beat(0, 1, 0, 0, 10);
    chk("sum_busy_open", 64'(busy[0]), 64'(1));
    chk("sum_no_err",    64'(err),     64'(0));
    beat(0, 0, 0, 0, 20);
    push(0, 60, 3, 0);
    beat(0, 0, 1, 0, 30);
    chk("sum_out_valid", 64'(out_valid), 64'(1));
    chk("sum_out_data",  64'(out_data),  64'(60));
    chk("sum_busy_clr",  64'(busy[0]),   64'(0));
    idle(2);

    // Interleaved ch1 MAX / ch2 MIN, back-to-back results
    beat(1, 1, 0, 2, 5);
    beat(2, 1, 0, 1, 7);
    beat(1, 0, 0, 0, 9);
    beat(2, 0, 0, 0, 3);
    push(1, 9, 3, 0);
    push(2, 3, 3, 0);
    beat(1, 0, 1, 0, 2);
    chk("b2b_first_valid", 64'(out_valid), 64'(1));
    chk("b2b_first_ch",    64'(out_ch),    64'(1));
    beat(2, 0, 1, 0, 8);
    chk("b2b_second_valid", 64'(out_valid), 64'(1));
    chk("b2b_second_ch",    64'(out_ch),    64'(2));
    chk("b2b_second_data",  64'(out_data),  64'(3));
    idle(2);

    // SUM overflow clamp and single-beat series
    beat(0, 1, 0, 0, 32'hFFFF_FFFF);
    beat(0, 0, 0, 0, 32'hFFFF_FFFF);
    push(0, 33'h1_FFFF_FFFF, 3, 1);
    beat(0, 0, 1, 0, 32'hFFFF_FFFF);
    push(3, 33'h42, 1, 0);
    beat(3, 1, 1, 0, 32'h42);
    chk("single_count", 64'(out_count), 64'(1));
    idle(2);

    // Backpressure: result held for 5 cycles
    out_ready = 1'b0;
    push(1, 7, 1, 0);
    beat(1, 1, 1, 1, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready",  64'(in_ready),  64'(0));
      chk("hold_out_valid", 64'(out_valid), 64'(1));
      chk("hold_out_data",  64'(out_data),  64'(7));
      chk("hold_out_ch",    64'(out_ch),    64'(1));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 64'(1));
    idle(2);

    // Protocol errors
    beat(3, 0, 1, 0, 99);
    chk("idle_last_err", 64'(err), 64'(1));
    idle(1);
    chk("idle_last_no_result", 64'(out_valid), 64'(0));
    chk("err_is_pulse",        64'(err),       64'(0));
    beat(0, 1, 0, 0, 100);
    chk("first_ok_no_err", 64'(err), 64'(0));
    beat(0, 1, 0, 0, 5);
    chk("first_busy_err", 64'(err), 64'(1));
    push(0, 11, 2, 0);
    beat(0, 0, 1, 0, 6);
    chk("restart_no_err", 64'(err), 64'(0));
    beat(2, 1, 0, 3, 4);
    chk("rsvd_mode_err", 64'(err), 64'(1));
    push(2, 10, 2, 0);
    beat(2, 0, 1, 2, 6);
    idle(2);

    // Count boundary: 255 beats fit, 256 saturate
    push(3, 255, 255, 0);
    for (int i = 0; i < 255; i++) beat(3, i == 0, i == 254, 0, 1);
    push(3, 256, 255, 1);
    for (int i = 0; i < 256; i++) beat(3, i == 0, i == 255, 0, 1);
    idle(2);

    // Reset mid-series on ch1
    beat(1, 1, 0, 0, 50);
    beat(1, 0, 0, 0, 100);
    chk("pre_rst_busy", 64'(busy[1]), 64'(1));
    #2 rst_n = 1'b0;
    #2;
    chk("mid_rst_busy",      64'(busy),      64'(0));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_data",  64'(out_data),  64'(0));
    chk("mid_rst_err",       64'(err),       64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);
    beat(1, 0, 1, 0, 9);
    chk("post_rst_idle_err", 64'(err), 64'(1));
    beat(1, 1, 0, 0, 3);
    push(1, 7, 2, 0);
    beat(1, 0, 1, 0, 4);
    idle(5);

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
